// File: rtl/count_step_ctrl_if.sv
// count_step_ctrl_if -- button/count bundle for count_step_ctrl.
//   inc_btn, dec_btn : debounced button levels (asynchronous to clk)
//   clr              : synchronous active-high clear
//   count            : registered count value, 0..MODULUS-1
//   step, wrap       : one-cycle pulses after a button-driven count change
// Modports: slave = the counter block, master = whoever drives the buttons.
interface count_step_ctrl_if;
   logic       inc_btn;
   logic       dec_btn;
   logic       clr;
   logic [3:0] count;
   logic       step;
   logic       wrap;

   modport slave (
      input  inc_btn,
      input  dec_btn,
      input  clr,
      output count,
      output step,
      output wrap
   );

   modport master (
      output inc_btn,
      output dec_btn,
      output clr,
      input  count,
      input  step,
      input  wrap
   );
endinterface

// File: rtl/count_step_ctrl.sv
// count_step_ctrl -- up/down modulo counter driven by two push buttons with
// optional hold-to-repeat.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : count_step_ctrl_if.slave (inc_btn, dec_btn, clr in; count, step, wrap out)
// Parameters: MODULUS (2..16), RPT_DELAY, RPT_PERIOD (1..2^24-1).
// Build option: define COUNT_STEP_AUTO_REPEAT_EN to compile in the hold/repeat
// timer; without it each press yields exactly one step and the RPT_* parameters
// are ignored.
module count_step_ctrl #(
   parameter int unsigned MODULUS    = 10,
   parameter int unsigned RPT_DELAY  = 5000000,
   parameter int unsigned RPT_PERIOD = 1000000
) (
   input logic            clk,
   input logic            reset,
   count_step_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      HOLD_INC,
      HOLD_DEC,
      RPT_INC,
      RPT_DEC,
      LOCK
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(MODULUS - 1);

   state_t     state, state_next;
   logic [1:0] inc_sync, dec_sync;
   logic       inc_prev, dec_prev;
   logic       inc_s, dec_s, inc_rise, dec_rise;
   logic [3:0] count, count_next;
   logic       step, step_next;
   logic       wrap, wrap_next;
   logic       do_step, step_dn;

   // Two-flop synchronizers plus the previous-value flops for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inc_sync <= '0;
         dec_sync <= '0;
         inc_prev <= 1'b0;
         dec_prev <= 1'b0;
      end else begin
         inc_sync <= {inc_sync[0], bus.inc_btn};
         dec_sync <= {dec_sync[0], bus.dec_btn};
         inc_prev <= inc_sync[1];
         dec_prev <= dec_sync[1];
      end
   end

   assign inc_s    = inc_sync[1];
   assign dec_s    = dec_sync[1];
   assign inc_rise = inc_s & ~inc_prev;
   assign dec_rise = dec_s & ~dec_prev;

`ifdef COUNT_STEP_AUTO_REPEAT_EN
   localparam logic [23:0] DELAY_LAST  = 24'(RPT_DELAY - 1);
   localparam logic [23:0] PERIOD_LAST = 24'(RPT_PERIOD - 1);

   logic [23:0] timer, timer_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) timer <= '0;
      else        timer <= timer_next;
   end
`else
   logic unused_rpt_cfg;
   assign unused_rpt_cfg = (RPT_DELAY > 0) ^ (RPT_PERIOD > 0);
`endif

   always_comb begin
      state_next = state;
      do_step    = 1'b0;
      step_dn    = 1'b0;
      case (state)
         IDLE: begin
            if (inc_s && dec_s) begin
               state_next = LOCK;
            end else if (inc_rise) begin
               do_step    = 1'b1;
               state_next = HOLD_INC;
            end else if (dec_rise) begin
               do_step    = 1'b1;
               step_dn    = 1'b1;
               state_next = HOLD_DEC;
            end
         end
         HOLD_INC: begin
            if (dec_s)       state_next = LOCK;
            else if (!inc_s) state_next = IDLE;
`ifdef COUNT_STEP_AUTO_REPEAT_EN
            else if (timer == DELAY_LAST) begin
               do_step    = 1'b1;
               state_next = RPT_INC;
            end
`endif
         end
         HOLD_DEC: begin
            if (inc_s)       state_next = LOCK;
            else if (!dec_s) state_next = IDLE;
`ifdef COUNT_STEP_AUTO_REPEAT_EN
            else if (timer == DELAY_LAST) begin
               do_step    = 1'b1;
               step_dn    = 1'b1;
               state_next = RPT_DEC;
            end
`endif
         end
`ifdef COUNT_STEP_AUTO_REPEAT_EN
         RPT_INC: begin
            if (dec_s)                      state_next = LOCK;
            else if (!inc_s)                state_next = IDLE;
            else if (timer == PERIOD_LAST)  do_step    = 1'b1;
         end
         RPT_DEC: begin
            if (inc_s)                      state_next = LOCK;
            else if (!dec_s)                state_next = IDLE;
            else if (timer == PERIOD_LAST) begin
               do_step = 1'b1;
               step_dn = 1'b1;
            end
         end
`endif
         LOCK: begin
            if (!inc_s && !dec_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      count_next = count;
      step_next  = 1'b0;
      wrap_next  = 1'b0;
      if (do_step) begin
         step_next = 1'b1;
         if (step_dn) begin
            wrap_next  = (count == 4'd0);
            count_next = wrap_next ? CNT_MAX : count - 4'd1;
         end else begin
            wrap_next  = (count == CNT_MAX);
            count_next = wrap_next ? 4'd0 : count + 4'd1;
         end
      end

`ifdef COUNT_STEP_AUTO_REPEAT_EN
      // Timer measures cycles since the last step; it restarts on every step
      // and idles at zero outside the hold/repeat states.
      if (do_step || state_next == IDLE || state_next == LOCK) timer_next = '0;
      else                                                      timer_next = timer + 24'd1;
`endif

      // Clear wins over any step decided in the same cycle.
      if (bus.clr) begin
         state_next = LOCK;
         count_next = 4'd0;
         step_next  = 1'b0;
         wrap_next  = 1'b0;
`ifdef COUNT_STEP_AUTO_REPEAT_EN
         timer_next = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= 4'd0;
         step  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         step  <= step_next;
         wrap  <= wrap_next;
      end
   end

   assign bus.count = count;
   assign bus.step  = step;
   assign bus.wrap  = wrap;

endmodule

// File: tb/tb_count_step_ctrl.sv
// tb_count_step_ctrl -- directed bench for count_step_ctrl
// (MODULUS=10, RPT_DELAY=8, RPT_PERIOD=4). Expectations for the hold test
// follow the COUNT_STEP_AUTO_REPEAT_EN setting of the build.
module tb_count_step_ctrl;

   logic clk;
   logic reset;
   count_step_ctrl_if bus ();

   count_step_ctrl #(
      .MODULUS    (10),
      .RPT_DELAY  (8),
      .RPT_PERIOD (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef COUNT_STEP_AUTO_REPEAT_EN
   localparam int unsigned HOLD_CYCLES = 30;
   localparam int unsigned HOLD_STEPS  = 7;
   localparam int unsigned HOLD_COUNT  = 7;
`else
   localparam int unsigned HOLD_CYCLES = 100;
   localparam int unsigned HOLD_STEPS  = 1;
   localparam int unsigned HOLD_COUNT  = 1;
`endif

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;
   int unsigned step_cnt = 0;
   int unsigned wrap_cnt = 0;
   logic        last_wrap = 1'b0;
   int unsigned step_edges[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Step observed at the negedge after edge n is attributed to edge n.
   always @(negedge clk) begin
      if (bus.step) begin
         step_cnt  = step_cnt + 1;
         last_wrap = bus.wrap;
         step_edges.push_back(cyc);
      end
      if (bus.wrap) wrap_cnt = wrap_cnt + 1;
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_inc(input int unsigned hold, input int unsigned gap);
      bus.inc_btn = 1'b1;
      idle(hold);
      bus.inc_btn = 1'b0;
      idle(gap);
   endtask

   task automatic press_dec(input int unsigned hold, input int unsigned gap);
      bus.dec_btn = 1'b1;
      idle(hold);
      bus.dec_btn = 1'b0;
      idle(gap);
   endtask

   int unsigned s0, w0, k;

   initial begin
      reset       = 1'b0;
      bus.inc_btn = 1'b0;
      bus.dec_btn = 1'b0;
      bus.clr     = 1'b0;
      idle(3);
      check("rst_count", bus.count, 0);
      check("rst_step", bus.step, 0);
      check("rst_wrap", bus.wrap, 0);
      reset = 1'b1;
      idle(3);

      // Ten short inc presses: 1..9 then wrap to 0.
      s0 = step_cnt;
      w0 = wrap_cnt;
      for (int i = 1; i <= 10; i++) begin
         press_inc(3, 6);
         check($sformatf("inc_press_%0d", i), bus.count, i % 10);
      end
      check("inc_press_steps", step_cnt - s0, 10);
      check("inc_press_wraps", wrap_cnt - w0, 1);
      check("inc_press_lastwrap", last_wrap, 1);

      // Decrement across zero, then once more.
      press_dec(3, 6);
      check("dec_wrap_count", bus.count, 9);
      check("dec_wrap_flag", last_wrap, 1);
      press_dec(3, 6);
      check("dec_count", bus.count, 8);
      check("dec_flag", last_wrap, 0);

      // Clear back to 0 with no step.
      s0 = step_cnt;
      bus.clr = 1'b1;
      idle(1);
      bus.clr = 1'b0;
      check("clr_count", bus.count, 0);
      idle(3);
      check("clr_nostep", step_cnt - s0, 0);

      // Hold inc: repeat timing (or a single step without auto-repeat).
      step_edges.delete();
      k = cyc + 1;
      press_inc(HOLD_CYCLES, 10);
      check("hold_steps", step_edges.size(), HOLD_STEPS);
`ifdef COUNT_STEP_AUTO_REPEAT_EN
      begin
         int unsigned offs[7];
         offs = '{2, 10, 14, 18, 22, 26, 30};
         for (int i = 0; i < 7; i++)
            if (i < step_edges.size())
               check($sformatf("hold_edge_%0d", i), step_edges[i] - k, offs[i]);
      end
`else
      if (step_edges.size() > 0) check("hold_edge_0", step_edges[0] - k, 2);
`endif
      check("hold_count", bus.count, HOLD_COUNT);

      // Both buttons together lock out stepping.
      s0 = step_cnt;
      bus.inc_btn = 1'b1;
      bus.dec_btn = 1'b1;
      idle(20);
      check("lock_both", step_cnt - s0, 0);
      bus.inc_btn = 1'b0;
      idle(10);
      check("lock_one", step_cnt - s0, 0);
      bus.dec_btn = 1'b0;
      idle(5);
      press_dec(3, 6);
      check("unlock_steps", step_cnt - s0, 1);
      check("unlock_count", bus.count, (HOLD_COUNT + 9) % 10);

      // Bring count to 5, then clear in the cycle the inc step would land.
      bus.clr = 1'b1;
      idle(1);
      bus.clr = 1'b0;
      idle(3);
      for (int i = 0; i < 5; i++) press_inc(3, 6);
      check("pre_clr_count", bus.count, 5);
      s0 = step_cnt;
      w0 = wrap_cnt;
      bus.inc_btn = 1'b1;
      idle(2);
      bus.clr = 1'b1;
      idle(1);
      bus.clr = 1'b0;
      check("clr_race_count", bus.count, 0);
      idle(20);
      check("clr_race_steps", step_cnt - s0, 0);
      check("clr_race_wraps", wrap_cnt - w0, 0);
      bus.inc_btn = 1'b0;
      idle(6);
      press_inc(3, 6);
      check("clr_repress_count", bus.count, 1);
      check("clr_repress_steps", step_cnt - s0, 1);

      // Reset mid-hold, then release with the button still high.
      bus.inc_btn = 1'b1;
      idle(12);
      reset = 1'b0;
      #1;
      check("midhold_rst_count", bus.count, 0);
      check("midhold_rst_step", bus.step, 0);
      s0 = step_cnt;
      idle(3);
      check("in_rst_steps", step_cnt - s0, 0);
      reset = 1'b1;
      idle(4);
      bus.inc_btn = 1'b0;
      idle(8);
      check("post_rst_steps", step_cnt - s0, 1);
      check("post_rst_count", bus.count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
